// File: rtl/wb_pkg.sv
// Shared types for the write-back writer: opcodes, write target, FSM states and queue entry.
package wb_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned RD_W   = 2;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0] OP_LOAD = 4'h8;
  localparam logic [OP_W-1:0] OP_LRW  = 4'h9;

  typedef enum logic {
    TGT_RF = 1'b0,
    TGT_LR = 1'b1
  } tgt_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  typedef struct packed {
    tgt_e              tgt;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  localparam int unsigned ENTRY_W = $bits(wb_entry_t);

  // ALU opcodes 0x0-0x7, LOAD and LRW produce a register write.
  function automatic logic op_writes(input logic [OP_W-1:0] op);
    return !op[OP_W-1] || (op == OP_LOAD) || (op == OP_LRW);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Pending-write queue; pointers carry one extra bit to tell full from empty.
// With WB_WRITER_FWD_EN defined the storage and pointers are exported for bypass lookup.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic               empty,
  output logic               full
`ifdef WB_WRITER_FWD_EN
  ,
  output logic [DEPTH*ENTRY_W-1:0] mem_flat,
  output logic [$clog2(DEPTH):0]   rptr,
  output logic [$clog2(DEPTH):0]   count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]        r_wptr;
  logic [AW:0]        r_rptr;
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic               w_push;
  logic               w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign head  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (w_push && !rst) r_mem[r_wptr[AW-1:0]] <= wdata;
  end

`ifdef WB_WRITER_FWD_EN
  always_comb begin
    mem_flat = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_flat[i*ENTRY_W +: ENTRY_W] = r_mem[i];
    end
  end

  assign rptr  = r_rptr;
  assign count = r_wptr - r_rptr;
`endif

endmodule

// File: rtl/wb_writer.sv
// Write-back writer: decodes the stage register, queues writes and replays them as SETUP/STROBE/HOLD.
// Optional macro WB_WRITER_FWD_EN adds fwd_valid/fwd_rd/fwd_data bypass outputs.
module wb_writer
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       insi,
  input  logic [DATA_W-1:0] alui,
  input  logic [DATA_W-1:0] memi,
  output logic              rf_we,
  output logic [RD_W-1:0]   rf_wd,
  output logic [DATA_W-1:0] rf_din,
  output logic              lr_we,
  output logic [DATA_W-1:0] lr_din,
  output logic              busy
`ifdef WB_WRITER_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  state_e       r_state;
  tgt_e         r_tgt;
  logic         r_live;

  logic [OP_W-1:0] w_op;
  logic            w_writes;
  wb_entry_t       w_entry;
  wb_entry_t       w_head;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic            w_full;
  logic            w_unused_bits;

  assign w_op          = insi[15:12];
  assign w_writes      = op_writes(w_op);
  assign w_unused_bits = ^insi[9:0];

  always_comb begin
    w_entry      = '0;
    w_entry.tgt  = (w_op == OP_LRW) ? TGT_LR : TGT_RF;
    w_entry.rd   = insi[11:10];
    w_entry.data = (w_op == OP_LOAD) ? memi : alui;
  end

  // Non-writing instructions are accepted but never enqueued.
  assign w_push   = in_valid && in_ready && w_writes;
  assign w_pop    = !w_empty && ((r_state == ST_IDLE) || (r_state == ST_HOLD));
  assign in_ready = r_live && !w_full;
  assign busy     = (r_state != ST_IDLE) || !w_empty;

`ifdef WB_WRITER_FWD_EN
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH*ENTRY_W-1:0] w_mem_flat;
  logic [AW:0]              w_fifo_rptr;
  logic [AW:0]              w_fifo_count;
  logic [AW-1:0]            w_fwd_idx;
  wb_entry_t                w_fwd_ent;
`endif

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .wdata (w_entry),
    .pop   (w_pop),
    .head  (w_head),
    .empty (w_empty),
    .full  (w_full)
`ifdef WB_WRITER_FWD_EN
    ,
    .mem_flat (w_mem_flat),
    .rptr     (w_fifo_rptr),
    .count    (w_fifo_count)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tgt   <= TGT_RF;
      r_live  <= 1'b0;
      rf_we   <= 1'b0;
      lr_we   <= 1'b0;
      rf_wd   <= '0;
      rf_din  <= '0;
      lr_din  <= '0;
    end else begin
      r_live <= 1'b1;
      rf_we  <= 1'b0;
      lr_we  <= 1'b0;
      case (r_state)
        ST_IDLE, ST_HOLD: begin
          if (w_pop) begin
            r_tgt   <= w_head.tgt;
            r_state <= ST_SETUP;
            if (w_head.tgt == TGT_RF) begin
              rf_wd  <= w_head.rd;
              rf_din <= w_head.data;
            end else begin
              lr_din <= w_head.data;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          r_state <= ST_STROBE;
          rf_we   <= (r_tgt == TGT_RF);
          lr_we   <= (r_tgt == TGT_LR);
        end
        ST_STROBE: r_state <= ST_HOLD;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef WB_WRITER_FWD_EN
  // In-flight write is oldest; queue entries are scanned oldest to youngest so the youngest wins.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_rd    = '0;
    fwd_data  = '0;
    w_fwd_idx = '0;
    w_fwd_ent = '0;
    if (((r_state == ST_SETUP) || (r_state == ST_STROBE)) && (r_tgt == TGT_RF)) begin
      fwd_valid = 1'b1;
      fwd_rd    = rf_wd;
      fwd_data  = rf_din;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_fwd_idx = w_fifo_rptr[AW-1:0] + AW'(i);
      w_fwd_ent = w_mem_flat[w_fwd_idx*ENTRY_W +: ENTRY_W];
      if (((AW+1)'(i) < w_fifo_count) && (w_fwd_ent.tgt == TGT_RF)) begin
        fwd_valid = 1'b1;
        fwd_rd    = w_fwd_ent.rd;
        fwd_data  = w_fwd_ent.data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_writer.sv
// Directed self-checking bench for wb_writer (DEPTH=2).
module tb_wb_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] insi = '0;
  logic [7:0]  alui = '0;
  logic [7:0]  memi = '0;
  logic        rf_we;
  logic [1:0]  rf_wd;
  logic [7:0]  rf_din;
  logic        lr_we;
  logic [7:0]  lr_din;
  logic        busy;
`ifdef WB_WRITER_FWD_EN
  logic        fwd_valid;
  logic [1:0]  fwd_rd;
  logic [7:0]  fwd_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int overlaps = 0;
  int ready_low = 0;

  int         s_cyc [$];
  logic       s_lr  [$];
  logic [1:0] s_rd  [$];
  logic [7:0] s_data[$];

  wb_writer #(.DEPTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .insi     (insi),
    .alui     (alui),
    .memi     (memi),
    .rf_we    (rf_we),
    .rf_wd    (rf_wd),
    .rf_din   (rf_din),
    .lr_we    (lr_we),
    .lr_din   (lr_din),
    .busy     (busy)
`ifdef WB_WRITER_FWD_EN
    ,
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log, sampled mid-cycle.
  always @(negedge clk) begin
    if (rf_we && lr_we) overlaps++;
    if (rf_we) begin
      s_cyc.push_back(cyc); s_lr.push_back(1'b0); s_rd.push_back(rf_wd); s_data.push_back(rf_din);
    end else if (lr_we) begin
      s_cyc.push_back(cyc); s_lr.push_back(1'b1); s_rd.push_back(2'd0); s_data.push_back(lr_din);
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one instruction and hold it until the transfer edge has passed.
  task automatic send(input logic [15:0] ins, input logic [7:0] a, input logic [7:0] m);
    int t = 0;
    in_valid = 1'b1; insi = ins; alui = a; memi = m;
    while (!in_ready && t < 20) begin
      ready_low++;
      step();
      t++;
    end
    if (t >= 20) check("send_timeout", 16'(in_ready), 16'd1);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int c0;

    // Reset with a writing instruction offered: it must be ignored.
    rst = 1'b1; in_valid = 1'b1; insi = 16'h1C00; alui = 8'hEE;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_rf_we",    16'(rf_we),    16'd0);
      check("rst_lr_we",    16'(lr_we),    16'd0);
      check("rst_rf_wd",    16'(rf_wd),    16'd0);
      check("rst_rf_din",   16'(rf_din),   16'd0);
      check("rst_lr_din",   16'(lr_din),   16'd0);
      check("rst_busy",     16'(busy),     16'd0);
      check("rst_in_ready", 16'(in_ready), 16'd0);
    end
    rst = 1'b0;
    step();
    in_valid = 1'b0;
    check("post_rst_in_ready", 16'(in_ready), 16'd1);
    check("post_rst_busy",     16'(busy),     16'd0);

    // Single RF write: op 1, rd 3, data A5.
    send(16'h1C00, 8'hA5, 8'h00);
    in_valid = 1'b0;
    check("single_busy_n",   16'(busy),   16'd1);
    check("single_we_n",     16'(rf_we),  16'd0);
    step();
    check("single_wd_n1",    16'(rf_wd),  16'd3);
    check("single_din_n1",   16'(rf_din), 16'hA5);
    check("single_we_n1",    16'(rf_we),  16'd0);
    step();
    check("single_we_n2",    16'(rf_we),  16'd1);
    check("single_lrwe_n2",  16'(lr_we),  16'd0);
    check("single_wd_n2",    16'(rf_wd),  16'd3);
    step();
    check("single_we_n3",    16'(rf_we),  16'd0);
    check("single_wd_n3",    16'(rf_wd),  16'd3);
    check("single_din_n3",   16'(rf_din), 16'hA5);
    check("single_lrdin_n3", 16'(lr_din), 16'h00);
    step();
    check("single_busy_n4",  16'(busy),   16'd0);

    // LOAD to rd 1 then LRW, back-to-back.
    base = s_cyc.size();
    send(16'h8400, 8'h11, 8'h3C);
    c0 = cyc;
    send(16'h9000, 8'h7E, 8'h99);
    in_valid = 1'b0;
    step(10);
    check("ldlr_count", 16'(s_cyc.size() - base), 16'd2);
    if (s_cyc.size() >= base + 2) begin
      check("ldlr_first_cyc", 16'(s_cyc[base] - c0),           16'd2);
      check("ldlr_first_lr",  16'(s_lr[base]),                 16'd0);
      check("ldlr_first_rd",  16'(s_rd[base]),                 16'd1);
      check("ldlr_first_dat", 16'(s_data[base]),               16'h3C);
      check("ldlr_gap",       16'(s_cyc[base+1] - s_cyc[base]), 16'd3);
      check("ldlr_second_lr", 16'(s_lr[base+1]),               16'd1);
      check("ldlr_second_dat",16'(s_data[base+1]),             16'h7E);
    end
    check("ldlr_hold_wd",  16'(rf_wd),  16'd1);
    check("ldlr_hold_din", 16'(rf_din), 16'h3C);
    check("ldlr_lr_din",   16'(lr_din), 16'h7E);
    check("ldlr_busy",     16'(busy),   16'd0);

    // Non-writing opcode is dropped.
    base = s_cyc.size();
    send(16'hF000, 8'h55, 8'h66);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("drop_busy", 16'(busy), 16'd0);
      step();
    end
    check("drop_no_strobe", 16'(s_cyc.size() - base), 16'd0);

    // Back-pressure: four writes offered every cycle.
    base = s_cyc.size();
    ready_low = 0;
    send(16'h2000, 8'h11, 8'h00);
    c0 = cyc;
    send(16'h2400, 8'h22, 8'h00);
    send(16'h2800, 8'h33, 8'h00);
    send(16'h2C00, 8'h44, 8'h00);
    in_valid = 1'b0;
    step(14);
    check("bp_ready_fell", 16'(ready_low > 0), 16'd1);
    check("bp_count", 16'(s_cyc.size() - base), 16'd4);
    if (s_cyc.size() >= base + 4) begin
      check("bp_first_cyc", 16'(s_cyc[base] - c0), 16'd2);
      for (int i = 0; i < 4; i++) begin
        check("bp_rd",   16'(s_rd[base+i]),   16'(i));
        check("bp_data", 16'(s_data[base+i]), 16'(8'h11 * (i + 1)));
        check("bp_lr",   16'(s_lr[base+i]),   16'd0);
        if (i > 0) check("bp_gap", 16'(s_cyc[base+i] - s_cyc[base+i-1]), 16'd3);
      end
    end
    check("bp_busy", 16'(busy), 16'd0);

    // Reset in STROBE with two writes still queued.
    send(16'h0800, 8'h5A, 8'h00);
    send(16'h0C00, 8'h6B, 8'h00);
    send(16'h0400, 8'h7C, 8'h00);
    check("mid_strobe",  16'(rf_we),  16'd1);
    check("mid_din",     16'(rf_din), 16'h5A);
    check("mid_ready_full", 16'(in_ready), 16'd0);
    rst = 1'b1;
    step();
    check("mid_rst_we",    16'(rf_we),    16'd0);
    check("mid_rst_busy",  16'(busy),     16'd0);
    check("mid_rst_ready", 16'(in_ready), 16'd0);
    check("mid_rst_din",   16'(rf_din),   16'd0);
    base = s_cyc.size();
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    check("mid_rel_ready", 16'(in_ready), 16'd1);
    for (int i = 0; i < 8; i++) begin
      check("mid_rel_busy", 16'(busy), 16'd0);
      step();
    end
    check("mid_no_strobe", 16'(s_cyc.size() - base), 16'd0);

    check("no_overlap", 16'(overlaps), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_writer.md
WB_WRITER -- requirements
Module: wb_writer

Interface
REQ-001 Parameter DEPTH, default 2: pending-write FIFO entries; power of two, at least 2.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 in_valid  input  1  the write-back stage presents an instruction and its results.
REQ-005 in_ready  output  1  a pending-write slot is free; a transfer occurs when in_valid && in_ready at a posedge.
REQ-006 insi  input  16  instruction from the write-back stage register.
REQ-007 alui  input  8  ALU result from the write-back stage register.
REQ-008 memi  input  8  memory read data from the write-back stage register.
REQ-009 rf_we  output  1  main-register write strobe; the register file captures on its rising edge.
REQ-010 rf_wd  output  2  main-register write address.
REQ-011 rf_din  output  8  main-register write data.
REQ-012 lr_we  output  1  LR write strobe; LR captures on its rising edge.
REQ-013 lr_din  output  8  LR write data.
REQ-014 busy  output  1  FSM is not IDLE, or the FIFO is not empty.

Function
REQ-015 Decode: opcode = insi[15:12] and rd = insi[11:10]; opcodes 0x0-0x7 write alui to main register rd; 0x8 (LOAD) writes memi to rd; 0x9 (LRW) writes alui to LR; all other opcodes write nothing.
REQ-016 A transferred instruction that writes nothing is dropped and is not enqueued.
REQ-017 A writing instruction is enqueued as {target (RF/LR), rd, data[7:0]}, in transfer order.
REQ-018 in_ready = FIFO not full, registered; there is no same-cycle pass-through when full, even if a pop occurs.
REQ-019 The FSM states are IDLE, SETUP, STROBE and HOLD.
REQ-020 IDLE to SETUP: when the FIFO is non-empty, pop the head into the output registers.
REQ-021 SETUP to STROBE: unconditional; this is the cycle in which the address and data settle.
REQ-022 STROBE to HOLD: unconditional.
REQ-023 HOLD: if the FIFO is non-empty, pop and go to SETUP; otherwise go to IDLE.
REQ-024 Strobes: rf_we (RF target) or lr_we (LR target) is high only during STROBE; both are low in every other state.
REQ-025 Strobe exclusivity: rf_we and lr_we are never high in the same cycle.
REQ-026 rf_wd, rf_din and lr_din are registered and stay constant from SETUP through HOLD.
REQ-027 Outside SETUP through HOLD, rf_wd, rf_din and lr_din hold their last values.
REQ-028 Latency: a transfer into an empty FIFO with the FSM in IDLE at edge N gives SETUP in cycle N+1 and STROBE in cycle N+2.
REQ-029 Throughput: back-to-back writes produce one write every 3 cycles.
REQ-030 A push and a pop in the same cycle are both performed, and the FIFO count is unchanged.
REQ-031 The FIFO read and write pointers wrap modulo DEPTH; full and empty are distinguished by an extra pointer bit.

Reset
REQ-032 While rst is high at a posedge: FSM to IDLE, FIFO emptied, rf_we=0, lr_we=0, rf_wd=0, rf_din=0, lr_din=0, busy=0, in_ready=0.
REQ-033 in_ready rises in the first cycle after rst deasserts.
REQ-034 Reset during STROBE drops the strobe low at that edge, and the in-flight write and all queued writes are discarded.
REQ-035 in_valid is ignored while rst is high.

Configuration
REQ-036 Macro WB_WRITER_FWD_EN, when defined, adds outputs fwd_valid (1), fwd_rd (2) and fwd_data (8).
REQ-037 With WB_WRITER_FWD_EN defined, these outputs report the youngest pending RF write to each register, covering FIFO entries plus the in-flight entry, so that decode can bypass it.
REQ-038 With WB_WRITER_FWD_EN defined, fwd_valid=1 when any RF-target write is pending, and fwd_rd and fwd_data reflect the youngest such write.
REQ-039 With WB_WRITER_FWD_EN undefined, the ports and logic are absent.

Structure
REQ-040 Package wb_pkg holds the opcode constants (OP_LOAD=4'h8, OP_LRW=4'h9), the target enum {TGT_RF, TGT_LR}, the FSM state enum, and the FIFO entry struct.
REQ-041 Sub-module wb_fifo (parameterised by DEPTH, synchronous reset) implements the pending-write queue; decode and the FSM stay in wb_writer.

Verification
REQ-042 Reset: assert rst for 2 cycles, then release -> all outputs 0 during reset; in_ready=1 the cycle after release.
REQ-043 Single write: insi=16'h1C00 (op 1, rd 3), alui=8'hA5 -> rf_wd=3 and rf_din=A5 at N+1; rf_we=1 only at N+2; all held through N+3; busy=0 at N+4.
REQ-044 Load and LR: insi=16'h8400 with memi=8'h3C, then insi=16'h9000 with alui=8'h7E, back-to-back -> rf_we strobe (rd 1, data 3C) followed 3 cycles later by lr_we strobe (data 7E); the two strobes never overlap.
REQ-045 Drop: insi=16'hF000 with in_valid=1 -> no strobe at all and busy stays 0.
REQ-046 Back-pressure: DEPTH=2, four writing instructions offered every cycle -> in_ready falls after the FIFO fills; all four strobes occur in order, exactly 3 cycles apart.
REQ-047 Mid-operation reset: assert rst in the STROBE cycle with 2 entries queued -> rf_we=0 next cycle; no further strobes; FIFO empty.
